// File: rtl/ffn_arbiter_pkg.sv
// Shared definitions for the FFN arbiter: FSM state encoding, Q8.8 element
// format constants and the default watchdog limit.
package ffn_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  // Q8.8 fixed-point element format.
  localparam int unsigned QIntBits  = 8;
  localparam int unsigned QFracBits = 8;
  localparam logic [15:0] QOne      = 16'h0100;

  localparam int unsigned DefaultTimeoutCycles = 64;

endpackage

// File: rtl/ffn_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
// Finds the first set request bit at or after ptr_i, wrapping NumReq-1 -> 0.
// Ports:
//   req_i  request vector
//   ptr_i  round-robin start index (must be < NumReq)
//   gnt_o  one-hot grant (all zero when no request)
//   idx_o  index of the granted bit (0 when no request)
//   any_o  at least one request present
module ffn_arbiter_rr_picker #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdW-1:0]    idx_o,
  output logic              any_o
);

  logic [IdW-1:0] cand;
  logic           found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdW'((32'(ptr_i) + i) % NumReq);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/ffn_arbiter.sv
// ffn_arbiter: shares one FFN datapath among NUM_REQ requesters.
// Flow: IDLE (round-robin grant, capture vector) -> ISSUE (one-cycle start
// pulse) -> WAIT (capture FFN result) -> RESP (hold until rsp handshake).
// Optional feature: define FFN_ARB_TIMEOUT_EN to add a WAIT watchdog; on
// expiry a zero response is returned with err_timeout set.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       per-requester handshake (ready one-hot, IDLE only)
//   req_x_flat                request vectors, requester k at slice k
//   ffn_valid_in/ffn_x_in     start pulse and vector to the FFN
//   ffn_valid_out/ffn_y_out   FFN result pulse and vector
//   rsp_valid/rsp_ready       response handshake; rsp_id/rsp_y payload
//   err_timeout               (FFN_ARB_TIMEOUT_EN only) response came from watchdog
//   busy                      high whenever not in IDLE
module ffn_arbiter
  import ffn_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned EMBED_DIM      = 4,
  parameter int unsigned DATA_WIDTH     = QIntBits + QFracBits,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles,
  localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned VecW = EMBED_DIM * DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*VecW-1:0]   req_x_flat,
  output logic                      ffn_valid_in,
  output logic [VecW-1:0]           ffn_x_in,
  input  logic [VecW-1:0]           ffn_y_out,
  input  logic                      ffn_valid_out,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IdW-1:0]            rsp_id,
  output logic [VecW-1:0]           rsp_y,
`ifdef FFN_ARB_TIMEOUT_EN
  output logic                      err_timeout,
`endif
  output logic                      busy
);

  arb_state_e     state_q, state_d;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0] id_q, id_d;
  logic [VecW-1:0] x_q, x_d;
  logic [VecW-1:0] y_q, y_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IdW-1:0]     pick_idx;
  logic               pick_any;

`ifdef FFN_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;
`endif

  ffn_arbiter_rr_picker #(
    .NumReq(NUM_REQ)
  ) u_rr_picker (
    .req_i(req_valid),
    .ptr_i(rr_ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    x_d      = x_q;
    y_d      = y_q;
`ifdef FFN_ARB_TIMEOUT_EN
    wd_cnt_d = wd_cnt_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          id_d    = pick_idx;
          x_d     = req_x_flat[pick_idx*VecW +: VecW];
          state_d = StIssue;
        end
      end
      StIssue: begin
`ifdef FFN_ARB_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        if (ffn_valid_out) begin
          y_d     = ffn_y_out;
          state_d = StResp;
`ifdef FFN_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Watchdog expired: answer with a zero vector flagged as an error.
          y_d     = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
`endif
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rr_ptr_d = (id_q == IdW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
`ifdef FFN_ARB_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      id_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
`ifdef FFN_ARB_TIMEOUT_EN
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      x_q      <= x_d;
      y_q      <= y_d;
`ifdef FFN_ARB_TIMEOUT_EN
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Grant is combinational so the requester sees accept in the same cycle.
  assign req_ready    = (state_q == StIdle) ? pick_gnt : '0;
  assign ffn_valid_in = (state_q == StIssue);
  assign ffn_x_in     = x_q;
  assign rsp_valid    = (state_q == StResp);
  assign rsp_id       = id_q;
  assign rsp_y        = y_q;
  assign busy         = (state_q != StIdle);
`ifdef FFN_ARB_TIMEOUT_EN
  assign err_timeout  = err_q;
`endif

endmodule

// File: tb/tb_ffn_arbiter.sv
// Self-checking bench for ffn_arbiter: directed scenarios plus a randomized
// phase, checked every cycle against a transaction-level reference model.
module tb_ffn_arbiter;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int W  = 16;
  localparam int TO = 64;
  localparam int VW = D * W;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*VW-1:0] req_x_flat;
  logic            ffn_valid_in;
  logic [VW-1:0]   ffn_x_in;
  logic [VW-1:0]   ffn_y_out;
  logic            ffn_valid_out;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [VW-1:0]   rsp_y;
  logic            busy;
`ifdef FFN_ARB_TIMEOUT_EN
  logic            err_timeout;
`endif

  always #5 clk = ~clk;

  ffn_arbiter #(
    .NUM_REQ(N),
    .EMBED_DIM(D),
    .DATA_WIDTH(W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_x_flat(req_x_flat),
    .ffn_valid_in(ffn_valid_in),
    .ffn_x_in(ffn_x_in),
    .ffn_y_out(ffn_y_out),
    .ffn_valid_out(ffn_valid_out),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_y(rsp_y),
`ifdef FFN_ARB_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FFN stand-in: y = 3*x + 1.0 per Q8.8 element, wrapping.
  function automatic logic [VW-1:0] ffn_f(input logic [VW-1:0] x);
    logic [VW-1:0] y;
    for (int e = 0; e < D; e++) y[e*W +: W] = x[e*W +: W] * 16'd3 + 16'h0100;
    return y;
  endfunction

  // Round-robin rule: first requester at or after ptr, wrapping.
  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Reference model state (one transaction at a time).
  bit            busy_m;
  int            ptr_m;
  int            exp_id;
  logic [VW-1:0] exp_x, exp_y;
  bit            exp_err;
  int            gcyc, lat_cur, cyc;
  int            gcount, issue_cnt;
  int            dut_grant, last_rsp_id, rv_rise;
  bit            prev_rv;

  // FFN stub state.
  int            ffn_lat = 5;
  bit            ffn_mute;
  bit            ffn_pend;
  int            ffn_cnt;
  logic [VW-1:0] ffn_hold;

  task automatic observe();
    logic [N-1:0] exp_rdy;
    bit           exp_vin, exp_rv;
    int           g;
    exp_rdy = '0;
    g = -1;
    if (!busy_m) begin
      g = rr_pick(ptr_m, req_valid);
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    check_eq("busy", 64'(busy), 64'(busy_m));
    for (int i = 0; i < N; i++) if (req_ready[i]) dut_grant = i;

    exp_vin = busy_m && (cyc == gcyc + 1);
    check_eq("ffn_valid_in", 64'(ffn_valid_in), 64'(exp_vin));
    if (ffn_valid_in) begin
      issue_cnt++;
      check_eq("ffn_x_in", ffn_x_in, exp_x);
      ffn_pend = !ffn_mute;
      ffn_cnt  = ffn_lat;
      ffn_hold = ffn_f(ffn_x_in);
    end

    exp_rv = busy_m && (cyc >= gcyc + 2 + lat_cur);
    check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (rsp_valid && !prev_rv) rv_rise = cyc;
    prev_rv = rsp_valid;
    if (rsp_valid && exp_rv) begin
      check_eq("rsp_id", 64'(rsp_id), 64'(exp_id));
      check_eq("rsp_y", rsp_y, exp_y);
`ifdef FFN_ARB_TIMEOUT_EN
      check_eq("err_timeout", 64'(err_timeout), 64'(exp_err));
`endif
    end

    if (g >= 0) begin
      busy_m  = 1'b1;
      exp_id  = g;
      exp_x   = req_x_flat[g*VW +: VW];
      gcyc    = cyc;
      lat_cur = ffn_mute ? TO : ffn_lat;
      exp_y   = ffn_mute ? '0 : ffn_f(exp_x);
      exp_err = ffn_mute;
      gcount++;
    end else if (busy_m && exp_rv && rsp_ready) begin
      busy_m      = 1'b0;
      ptr_m       = (exp_id + 1) % N;
      last_rsp_id = int'(rsp_id);
    end
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    ffn_valid_out = 1'b0;
    ffn_y_out     = {$urandom, $urandom};
    if (ffn_pend) begin
      ffn_cnt--;
      if (ffn_cnt == 0) begin
        ffn_pend      = 1'b0;
        ffn_valid_out = 1'b1;
        ffn_y_out     = ffn_hold;
      end
    end
    #1;
    cyc++;
    if (rst) begin
      busy_m  = 1'b0;
      ptr_m   = 0;
      prev_rv = 1'b0;
    end else begin
      observe();
    end
    @(negedge clk);
  endtask

  task automatic rand_vectors();
    req_x_flat = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_grant(input string tag);
    int target;
    target = gcount + 1;
    for (int k = 0; k < 300 && gcount < target; k++) cycle();
    check_eq(tag, 64'(gcount), 64'(target));
  endtask

  task automatic drain(input string tag);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 300 && busy_m; k++) cycle();
    check_eq(tag, 64'(busy), 64'(0));
  endtask

  task automatic check_reset_state(input string p);
    check_eq({p, "_req_ready"}, 64'(req_ready), 64'(0));
    check_eq({p, "_ffn_valid_in"}, 64'(ffn_valid_in), 64'(0));
    check_eq({p, "_ffn_x_in"}, ffn_x_in, 64'(0));
    check_eq({p, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check_eq({p, "_rsp_id"}, 64'(rsp_id), 64'(0));
    check_eq({p, "_rsp_y"}, rsp_y, 64'(0));
    check_eq({p, "_busy"}, 64'(busy), 64'(0));
`ifdef FFN_ARB_TIMEOUT_EN
    check_eq({p, "_err_timeout"}, 64'(err_timeout), 64'(0));
`endif
  endtask

  initial begin
    int order[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int base_issue, base_grant;

    rst           = 1'b1;
    req_valid     = '0;
    req_x_flat    = '0;
    ffn_valid_out = 1'b0;
    ffn_y_out     = '0;
    rsp_ready     = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    check_reset_state("reset");

    // Round-robin order with every requester active and response taken at once.
    ffn_lat   = 3;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_vectors();
      wait_grant("rr_grant");
      order[i] = dut_grant;
    end
    for (int i = 0; i < 5; i++) check_eq("rr_order", 64'(order[i]), 64'(exp_order[i]));
    drain("rr_drain");

    // Single request from requester 2 with x = {1.0, 0, 0, 0}.
    ffn_lat    = 5;
    issue_cnt  = 0;
    req_x_flat = '0;
    req_x_flat[2*VW +: VW] = {16'h0000, 16'h0000, 16'h0000, 16'h0100};
    req_valid  = 4'b0100;
    wait_grant("single_grant");
    req_valid = '0;
    drain("single_drain");
    check_eq("single_issues", 64'(issue_cnt), 64'(1));
    check_eq("single_rsp_id", 64'(last_rsp_id), 64'(2));
    check_eq("single_latency", 64'(rv_rise - gcyc), 64'(7));

    // Response back-pressure: hold rsp_ready low for 10 cycles in RESP.
    rsp_ready = 1'b0;
    rand_vectors();
    req_valid = 4'b1011;
    for (int k = 0; k < 100 && !rsp_valid; k++) cycle();
    check_eq("hold_reached_resp", 64'(rsp_valid), 64'(1));
    base_issue = issue_cnt;
    base_grant = gcount;
    for (int k = 0; k < 10; k++) begin
      rand_vectors();
      cycle();
    end
    check_eq("hold_no_issue", 64'(issue_cnt - base_issue), 64'(0));
    check_eq("hold_no_grant", 64'(gcount - base_grant), 64'(0));
    check_eq("hold_rsp_valid", 64'(rsp_valid), 64'(1));
    drain("hold_drain");

    // Reset while waiting on the FFN, then a late FFN result.
    ffn_lat   = 5;
    rsp_ready = 1'b1;
    rand_vectors();
    req_valid = 4'b0100;
    wait_grant("rst_grant");
    req_valid = '0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset_state("midrst");
    for (int k = 0; k < 8; k++) cycle();
    check_eq("midrst_late_rsp", 64'(rsp_valid), 64'(0));
    req_valid = '1;
    rand_vectors();
    wait_grant("midrst_regrant");
    check_eq("midrst_first_id", 64'(dut_grant), 64'(0));
    drain("midrst_drain");

`ifdef FFN_ARB_TIMEOUT_EN
    // FFN never answers: watchdog produces a zero, flagged response.
    ffn_mute  = 1'b1;
    rand_vectors();
    req_valid = 4'b0001;
    wait_grant("to_grant");
    req_valid = '0;
    drain("to_drain");
    check_eq("to_latency", 64'(rv_rise - gcyc), 64'(2 + TO));
    ffn_mute = 1'b0;
`endif

    // Randomized traffic: requests appear and vanish freely.
    for (int k = 0; k < 1500; k++) begin
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_vectors();
      if (!busy_m && !ffn_pend) begin
        ffn_lat = $urandom_range(1, 8);
`ifdef FFN_ARB_TIMEOUT_EN
        ffn_mute = ($urandom_range(0, 15) == 0);
`endif
      end
      cycle();
    end
    ffn_mute = 1'b0;
    drain("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ffn_arbiter.md
FFN_ARBITER -- requirements
Module: ffn_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one FFN datapath.
REQ-002 SHALL have parameter EMBED_DIM, default 4, elements per token vector.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, Q8.8 element width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, watchdog limit in cycles.
REQ-005 SHALL have port clk  input  1  clock; the only clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port req_valid  input  NUM_REQ  per-requester request valid.
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester accept, at most one bit set.
REQ-009 SHALL have port req_x_flat  input  NUM_REQ*EMBED_DIM*DATA_WIDTH  request vectors, requester k at slice k.
REQ-010 SHALL have port ffn_valid_in  output  1  start pulse to the FFN datapath.
REQ-011 SHALL have port ffn_x_in  output  EMBED_DIM*DATA_WIDTH  vector to the FFN datapath.
REQ-012 SHALL have port ffn_y_out  input  EMBED_DIM*DATA_WIDTH  FFN result.
REQ-013 SHALL have port ffn_valid_out  input  1  FFN result valid, single-cycle pulse.
REQ-014 SHALL have port rsp_valid  output  1  response valid.
REQ-015 SHALL have port rsp_ready  input  1  response consumer ready.
REQ-016 SHALL have port rsp_id  output  clog2(NUM_REQ)  index of the requester the response belongs to.
REQ-017 SHALL have port rsp_y  output  EMBED_DIM*DATA_WIDTH  response vector.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-020 IDLE: on any req_valid set, grant the first set bit at or after rr_ptr (round-robin, wrapping at NUM_REQ-1 -> 0), assert that req_ready combinationally in the same cycle, register the vector and id, go to ISSUE.
REQ-021 ISSUE: drive ffn_valid_in high for exactly one cycle with ffn_x_in = the registered vector, clear the watchdog counter, go to WAIT.
REQ-022 WAIT: on ffn_valid_out, register ffn_y_out into rsp_y, go to RESP; ffn_valid_out in any other state SHALL be ignored.
REQ-023 RESP: hold rsp_valid, rsp_id and rsp_y stable until rsp_valid && rsp_ready; on that handshake set rr_ptr = granted id + 1 (mod NUM_REQ) and go to IDLE.
REQ-024 req_ready SHALL be all-zero outside IDLE; at most one grant is in flight.
REQ-025 Minimum grant-to-response latency SHALL be 2 + FFN latency cycles (FFN latency 5 gives rsp_valid in the 7th cycle after the grant).
REQ-026 A requester that drops req_valid before it is granted SHALL be skipped without side effects.
REQ-027 rsp_ready held high in RESP SHALL allow IDLE to grant again on the following cycle, giving back-to-back service.

Reset
REQ-028 rst SHALL force IDLE, rr_ptr=0 and the watchdog counter to 0, and SHALL drive req_ready, ffn_valid_in, rsp_valid, rsp_id, rsp_y, busy (and err_timeout) to 0 on the next edge.
REQ-029 rst asserted mid-transaction SHALL abandon the in-flight request with no response; a late ffn_valid_out SHALL then be ignored.

Configuration
REQ-030 Macro FFN_ARB_TIMEOUT_EN: when defined, WAIT counts cycles, and on reaching TIMEOUT_CYCLES without ffn_valid_out it SHALL go to RESP with rsp_y=0 and an output err_timeout (1 bit) = 1 accompanying that response.
REQ-031 Without FFN_ARB_TIMEOUT_EN, neither the counter nor the err_timeout port SHALL exist, and WAIT SHALL wait indefinitely.

Structure
REQ-032 A shared package SHALL hold the FSM state encodings, Q8.8 format constants and the default TIMEOUT_CYCLES.
REQ-033 A sub-module rr_picker (combinational: request vector + pointer -> one-hot grant + index) SHALL be used.

Verification
REQ-034 A single request from requester 2 with x={256,0,0,0} against an FFN model -> one ffn_valid_in pulse, rsp_id=2, rsp_y equal to the model output.
REQ-035 All four requesters held valid with rsp_ready=1 -> grant order 0,1,2,3,0.
REQ-036 rsp_ready held 0 for 10 cycles in RESP -> rsp fields stable, no new grant, ffn_valid_in not reasserted.
REQ-037 rst pulsed in WAIT, followed by a late ffn_valid_out -> outputs 0, no rsp_valid, next grant goes to requester 0.
REQ-038 FFN_ARB_TIMEOUT_EN defined and the FFN model never responds -> rsp_valid after 64 WAIT cycles with err_timeout=1 and rsp_y=0.
